// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: byte stores queue into a small FIFO and are
// sent 8N1 LSB first; define UART_TX_PARITY_EN to append an even-parity bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [7:0]         wr_data_i,
  output logic               tx_o,
  output logic               fifo_full_o,
  output logic [FIFO_AW:0]   fifo_count_o,
  output logic               busy_o,
  output logic               overflow_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e             state_q, state_d;
  logic [CW-1:0]      baudCnt_q, baudCnt_d;
  logic [2:0]         bitIdx_q, bitIdx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [FIFO_AW-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_AW-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic       baudLast;
  logic       full;
  logic       notEmpty;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign baudLast = (baudCnt_q == BAUD_LAST);
  assign full     = (count_q == COUNT_FULL);
  assign notEmpty = (count_q != '0);
  assign push     = wr_en_i & ~full;
  assign head     = mem_q[rdPtr_q];

  always_comb begin
    state_d   = state_q;
    baudCnt_d = (state_q == IDLE || baudLast) ? '0 : baudCnt_q + CW'(1);
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (notEmpty) begin
          pop      = 1'b1;
          shift_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baudLast) begin
          tx_d     = shift_q[0];
          bitIdx_d = 3'd0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baudLast) begin
          if (bitIdx_q != 3'd7) begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudLast) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit so queued frames have no gap.
        if (baudLast) begin
          if (notEmpty) begin
            pop      = 1'b1;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Full is the registered flag, so a same-edge pop never rescues a write.
  always_comb begin
    wrPtr_d    = push ? wrPtr_q + FIFO_AW'(1) : wrPtr_q;
    rdPtr_d    = pop ? rdPtr_q + FIFO_AW'(1) : rdPtr_q;
    overflow_d = overflow_q | (wr_en_i & full);
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wrPtr_q] <= wr_data_i;
    end
  end

  assign tx_o         = tx_q;
  assign fifo_full_o  = full;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != IDLE) | notEmpty;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4: a table of single frames
// with hand-computed bit patterns plus sequences for queueing and reset corners.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    logic [9:0] expFrame;
    logic       expParity;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEn;
  logic [7:0]    wrData;
  logic          tx;
  logic          fifoFull;
  logic [AW:0]   fifoCount;
  logic          busy;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  vec_t tbl [7];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (AW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wrEn),
    .wr_data_i   (wrData),
    .tx_o        (tx),
    .fifo_full_o (fifoFull),
    .fifo_count_o(fifoCount),
    .busy_o      (busy),
    .overflow_o  (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] d);
    wrEn   = en;
    wrData = d;
    @(negedge clk);
  endtask

  // Expected line level for bit slot b of a frame carrying d.
  function automatic logic modelBit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  function automatic logic tableBit(input vec_t v, input int b);
    if (b <= 8) return v.expFrame[b];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return v.expParity;
`endif
    return v.expFrame[9];
  endfunction

  // Checks tx on every cycle of a frame from cycle firstCycle to the end;
  // optionally presents a write during the final cycle of the frame.
  task automatic expectFrame(input logic [7:0] d, input int firstCycle, input logic injEn,
                             input logic [7:0] injData, input string tag);
    for (int j = firstCycle; j < FB * CPB; j++) begin
      checkOutput($sformatf("%s_tx_c%0d", tag, j), {31'd0, tx}, {31'd0, modelBit(d, j / CPB)});
      if (j == FB * CPB - 1) begin
        checkOutput($sformatf("%s_busy_end", tag), {31'd0, busy}, 32'd1);
        if (injEn) begin
          wrEn   = 1'b1;
          wrData = injData;
        end
      end
      @(negedge clk);
      wrEn = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] bytesSim [5];
    bytesSim[0] = 8'h3C; bytesSim[1] = 8'h5A; bytesSim[2] = 8'hC3;
    bytesSim[3] = 8'h81; bytesSim[4] = 8'h7E;

    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[4] = '{8'h03, 10'b1000000110, 1'b0};
    tbl[5] = '{8'h80, 10'b1100000000, 1'b1};
    tbl[6] = '{8'h01, 10'b1000000010, 1'b1};

    rst    = 1'b1;
    wrEn   = 1'b0;
    wrData = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx",       {31'd0, tx},        32'd1);
    checkOutput("rst_count",    {28'd0, fifoCount}, 32'd0);
    checkOutput("rst_full",     {31'd0, fifoFull},  32'd0);
    checkOutput("rst_busy",     {31'd0, busy},      32'd0);
    checkOutput("rst_overflow", {31'd0, overflow},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames from idle, compared against the hand-computed table.
    for (int r = 0; r < 7; r++) begin
      applyStimulus(1'b1, tbl[r].data);
      wrEn = 1'b0;
      checkOutput($sformatf("tbl%0d_count_after_wr", r), {28'd0, fifoCount}, 32'd1);
      checkOutput($sformatf("tbl%0d_tx_before_start", r), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("tbl%0d_busy_queued", r), {31'd0, busy}, 32'd1);
      @(negedge clk);
      for (int j = 0; j < FB * CPB; j++) begin
        if (j == 0)
          checkOutput($sformatf("tbl%0d_count_after_pop", r), {28'd0, fifoCount}, 32'd0);
        checkOutput($sformatf("tbl%0d_tx_c%0d", r, j), {31'd0, tx}, {31'd0, tableBit(tbl[r], j / CPB)});
        @(negedge clk);
      end
      checkOutput($sformatf("tbl%0d_busy_done", r), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("tbl%0d_tx_idle", r), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("tbl%0d_overflow", r), {31'd0, overflow}, 32'd0);
    end

    // Back-to-back writes: second frame must follow the first stop bit directly.
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    wrEn = 1'b0;
    checkOutput("b2b_count", {28'd0, fifoCount}, 32'd1);
    expectFrame(8'h00, 0, 1'b0, 8'h00, "b2b0");
    checkOutput("b2b_count_second_pop", {28'd0, fifoCount}, 32'd0);
    expectFrame(8'hFF, 0, 1'b0, 8'h00, "b2b1");
    checkOutput("b2b_busy_done", {31'd0, busy}, 32'd0);

    // Ten consecutive writes: nine fit (one popped after a cycle), tenth drops.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(8'h10 + k));
      checkOutput($sformatf("ovf_count_w%0d", k), {28'd0, fifoCount},
                  (k == 0) ? 32'd1 : ((k <= 8) ? 32'(k) : 32'd8));
      checkOutput($sformatf("ovf_full_w%0d", k), {31'd0, fifoFull}, (k >= 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ovf_flag_w%0d", k), {31'd0, overflow}, (k == 9) ? 32'd1 : 32'd0);
    end
    wrEn = 1'b0;
    expectFrame(8'h10, 8, 1'b0, 8'h00, "ovf_b0");
    for (int k = 1; k < 9; k++)
      expectFrame(8'(8'h10 + k), 0, 1'b0, 8'h00, $sformatf("ovf_b%0d", k));
    checkOutput("ovf_busy_done", {31'd0, busy}, 32'd0);
    checkOutput("ovf_count_done", {28'd0, fifoCount}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Write landing on the same edge as the STOP-to-START pop with three queued.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, bytesSim[k]);
    wrEn = 1'b0;
    checkOutput("sim_count_before", {28'd0, fifoCount}, 32'd3);
    expectFrame(bytesSim[0], 2, 1'b1, bytesSim[4], "simA");
    checkOutput("sim_count_after", {28'd0, fifoCount}, 32'd3);
    checkOutput("sim_start_bit", {31'd0, tx}, 32'd0);
    for (int k = 1; k < 5; k++)
      expectFrame(bytesSim[k], 0, 1'b0, 8'h00, $sformatf("sim%0d", k));
    checkOutput("sim_busy_done", {31'd0, busy}, 32'd0);
    checkOutput("sim_overflow_kept", {31'd0, overflow}, 32'd1);

    // Reset during data bit 3 of the first frame with two bytes still queued.
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h66);
    applyStimulus(1'b1, 8'h77);
    wrEn = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("rstmid_tx_bit3", {31'd0, tx}, 32'd0);
    checkOutput("rstmid_count_before", {28'd0, fifoCount}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_tx", {31'd0, tx}, 32'd1);
    checkOutput("rstmid_count", {28'd0, fifoCount}, 32'd0);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rstmid_full", {31'd0, fifoFull}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rstmid_quiet_tx_c%0d", c), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("rstmid_quiet_busy_c%0d", c), {31'd0, busy}, 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    applyStimulus(1'b1, 8'h07);
    applyStimulus(1'b1, 8'h03);
    wrEn = 1'b0;
    expectFrame(8'h07, 0, 1'b0, 8'h00, "par07");
    expectFrame(8'h03, 0, 1'b0, 8'h00, "par03");
    checkOutput("par_busy_done", {31'd0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
